// File: rtl/i2c_pkg.sv
// Shared I2C constants: bus idle level, default conditioner parameters and
// the filter counter width helper.
package i2c_pkg;

  localparam logic        I2C_IDLE        = 1'b1;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FLT_CYC     = 4;

  // Counter must hold 0..FLT_CYC-1; a 1-clock filter still gets one bit.
  function automatic int unsigned flt_cnt_w(input int unsigned flt_cyc);
    return (flt_cyc > 1) ? $clog2(flt_cyc) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_flt.sv
// One I2C line: synchronizer chain, stability counter, filtered flop and
// registered rise/fall pulses. The _c outputs are the combinational update strobes.
module i2c_line_flt
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FLT_CYC     = DEF_FLT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic line_f,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned     CNT_W   = flt_cnt_w(FLT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   upd_c;

  // Synchronizer chain, preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{I2C_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Count consecutive clocks of disagreement; accept on the FLT_CYC-th.
  always_comb begin
    cnt_d = '0;
    upd_c = 1'b0;
    if (s != line_f) begin
      if (cnt_q == CNT_MAX) begin
        upd_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise_c = upd_c & s;
  assign fall_c = upd_c & ~s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_f <= I2C_IDLE;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      line_f <= upd_c ? s : line_f;
      rise   <= rise_c;
      fall   <= fall_c;
    end
  end

endmodule

// File: rtl/i2c_bus_filter.sv
// I2C receive-side conditioner: filtered SCL/SDA, SCL edge pulses and, when
// I2C_FLT_COND_EN is defined, START/STOP detection with BUS_BUSY.
module i2c_bus_filter
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FLT_CYC     = DEF_FLT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);

  logic scl_rise_c;
  logic scl_fall_c;
  logic sda_rise_c;
  logic sda_fall_c;
  logic sda_rise;
  logic sda_fall;

  i2c_line_flt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FLT_CYC     (FLT_CYC)
  ) u_scl (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (scl_in),
    .line_f (scl_f),
    .rise   (scl_rise),
    .fall   (scl_fall),
    .rise_c (scl_rise_c),
    .fall_c (scl_fall_c)
  );

  i2c_line_flt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FLT_CYC     (FLT_CYC)
  ) u_sda (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin    (sda_in),
    .line_f (sda_f),
    .rise   (sda_rise),
    .fall   (sda_fall),
    .rise_c (sda_rise_c),
    .fall_c (sda_fall_c)
  );

`ifdef I2C_FLT_COND_EN
  logic scl_hold_c;
  logic start_c;
  logic stop_c;

  // SDA transition counts only while filtered SCL is high and not moving this edge.
  always_comb begin
    scl_hold_c = scl_f & ~(scl_rise_c | scl_fall_c);
    start_c    = scl_hold_c & sda_fall_c;
    stop_c     = scl_hold_c & sda_rise_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      start_det <= start_c;
      stop_det  <= stop_c;
      if (start_c) begin
        bus_busy <= 1'b1;
      end else if (stop_c) begin
        bus_busy <= 1'b0;
      end
    end
  end

  logic unused_sda_pulse;
  assign unused_sda_pulse = sda_rise ^ sda_fall;
`else
  logic unused_cond;
  assign unused_cond = ^{scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c, sda_rise, sda_fall};

  assign start_det = 1'b0;
  assign stop_det  = 1'b0;
  assign bus_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Self-checking bench for i2c_bus_filter: directed bus scenarios plus random
// pin activity, compared each cycle against a sliding-window reference model.
module tb_i2c_bus_filter;

  localparam int unsigned S = 2;
  localparam int unsigned F = 4;
  localparam int unsigned P = 8;
`ifdef I2C_FLT_COND_EN
  localparam int COND = 1;
`else
  localparam int COND = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic scl_pin, sda_pin;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;

  i2c_bus_filter #(.SYNC_STAGES(S), .FLT_CYC(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_pin),
    .sda_in    (sda_pin),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pin history and synchronized-level history per line.
  // A line accepts a new level once the last F synchronized samples all disagree with it.
  logic [63:0] ph [2];
  logic [63:0] sh [2];
  logic        m_f [2];
  logic        m_rise [2];
  logic        m_fall [2];
  logic        m_start, m_stop, m_busy;

  function automatic logic win_all(input logic [63:0] h, input logic v);
    for (int i = 0; i < int'(F); i++) if (h[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : p_model
    logic [63:0] nsh [2];
    logic [63:0] nph [2];
    logic        nf  [2];
    logic        st, sp;
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        ph[l] <= '1; sh[l] <= '1; m_f[l] <= 1'b1; m_rise[l] <= 1'b0; m_fall[l] <= 1'b0;
      end
      m_start <= 1'b0; m_stop <= 1'b0; m_busy <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        nsh[l] = {sh[l][62:0], ph[l][S-1]};
        nf[l]  = win_all(nsh[l], ~m_f[l]) ? ~m_f[l] : m_f[l];
        nph[l] = {ph[l][62:0], (l == 0) ? scl_pin : sda_pin};
        ph[l]     <= nph[l];
        sh[l]     <= nsh[l];
        m_f[l]    <= nf[l];
        m_rise[l] <= nf[l] & ~m_f[l];
        m_fall[l] <= ~nf[l] & m_f[l];
      end
      st = (COND != 0) && m_f[0] && nf[0] && m_f[1] && !nf[1];
      sp = (COND != 0) && m_f[0] && nf[0] && !m_f[1] && nf[1];
      m_start <= st;
      m_stop  <= sp;
      m_busy  <= st ? 1'b1 : (sp ? 1'b0 : m_busy);
    end
  end

  bit run_chk = 1'b0;
  int c_srise = 0, c_sfall = 0, c_start = 0, c_stop = 0, c_busy = 0, c_sdalow = 0;

  // Cycle-by-cycle comparison and pulse bookkeeping, away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("scl_f", scl_f, m_f[0]);
      chk("sda_f", sda_f, m_f[1]);
      chk("scl_rise", scl_rise, m_rise[0]);
      chk("scl_fall", scl_fall, m_fall[0]);
      chk("start_det", start_det, m_start);
      chk("stop_det", stop_det, m_stop);
      chk("bus_busy", bus_busy, m_busy);
    end
    c_srise  += int'(scl_rise);
    c_sfall  += int'(scl_fall);
    c_start  += int'(start_det);
    c_stop   += int'(stop_det);
    c_busy   += int'(bus_busy);
    c_sdalow += int'(!sda_f);
  end

  task automatic set_pins(input logic c, input logic d, input int n);
    scl_pin = c;
    sda_pin = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scl_f"}, scl_f, 1);
    chk({tag, "_sda_f"}, sda_f, 1);
    chk({tag, "_pulses"}, {scl_rise, scl_fall, start_det, stop_det}, 0);
    chk({tag, "_busy"}, bus_busy, 0);
  endtask

  initial begin
    int n;
    int b_rise, b_fall, b_start, b_stop, b_busy, b_low;
    logic [8:0] data;
    logic [8:0] dbits;
    int hs, hd;

    scl_pin = 1'b1;
    sda_pin = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk);
    rst_n   = 1'b1;
    run_chk = 1'b1;
    set_pins(1, 1, P);

    // SCL low for 10 clocks: latency and single fall pulse
    b_rise = c_srise; b_fall = c_sfall; b_start = c_start; b_stop = c_stop;
    scl_pin = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (scl_f && n < 20);
    chk("scl_latency", n, S + F);
    repeat (10 - n) @(negedge clk);
    set_pins(0, 1, 4);
    chk("scl_fall_cnt", c_sfall - b_fall, 1);
    chk("scl_rise_cnt", c_srise - b_rise, 0);
    chk("no_cond", (c_start - b_start) + (c_stop - b_stop), 0);
    set_pins(1, 1, P + 4);
    chk("scl_rise_back", c_srise - b_rise, 1);

    // SDA spikes with SCL high: 3 clocks rejected, 4 clocks passed
    b_start = c_start; b_low = c_sdalow;
    set_pins(1, 0, F - 1);
    set_pins(1, 1, 12);
    chk("spike3_sda", c_sdalow - b_low, 0);
    chk("spike3_start", c_start - b_start, 0);
    b_start = c_start; b_stop = c_stop; b_busy = c_busy; b_low = c_sdalow;
    set_pins(1, 0, F);
    set_pins(1, 1, 12);
    chk("spike4_sda", c_sdalow - b_low, F);
    chk("spike4_start", c_start - b_start, COND);
    chk("spike4_stop", c_stop - b_stop, COND);
    chk("spike4_busy", c_busy - b_busy, COND * F);

    // Byte transfer with ACK, repeated START, then STOP
    data = 9'($urandom);
    b_start = c_start; b_stop = c_stop;
    set_pins(1, 0, P);
    set_pins(0, 0, P);
    b_rise = c_srise; b_fall = c_sfall;
    for (int i = 0; i < 9; i++) begin
      dbits = data;
      set_pins(0, dbits[i], P);
      set_pins(1, dbits[i], P);
      set_pins(0, dbits[i], P);
    end
    chk("byte_rise", c_srise - b_rise, 9);
    chk("byte_fall", c_sfall - b_fall, 9);
    chk("byte_start", c_start - b_start, COND);
    chk("byte_stop", c_stop - b_stop, 0);
    chk("byte_busy", bus_busy, COND);
    b_start = c_start;
    set_pins(0, 1, P);
    set_pins(1, 1, P);
    set_pins(1, 0, P);
    set_pins(0, 0, P);
    chk("rs_start", c_start - b_start, COND);
    chk("rs_busy", bus_busy, COND);
    set_pins(1, 0, P);
    set_pins(1, 1, P);
    chk("stop_cnt", c_stop - b_stop, COND);
    chk("stop_busy", bus_busy, 0);

    // Both pins change in the same clock from idle
    b_fall = c_sfall; b_rise = c_srise; b_start = c_start; b_stop = c_stop;
    set_pins(0, 0, 12);
    chk("simul_fall", c_sfall - b_fall, 1);
    chk("simul_start", c_start - b_start, 0);
    set_pins(1, 1, 12);
    chk("simul_rise", c_srise - b_rise, 1);
    chk("simul_stop", c_stop - b_stop, 0);

    // Asynchronous reset while busy with both lines held low
    set_pins(1, 0, P);
    set_pins(0, 0, P);
    chk("pre_rst_busy", bus_busy, COND);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    b_fall = c_sfall; b_start = c_start;
    rst_n = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (sda_f && n < 20);
    chk("rst_sda_latency", n, S + F - 1);
    repeat (6) @(negedge clk);
    chk("rst_no_start", c_start - b_start, 0);
    chk("rst_scl_fall", c_sfall - b_fall, 1);
    set_pins(1, 1, 12);

    // Random pin activity, including sub-filter glitches
    hs = 0; hd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hs == 0) begin scl_pin = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 8); end
      if (hd == 0) begin sda_pin = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 8); end
      hs--; hd--;
      @(negedge clk);
    end
    set_pins(1, 1, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
